seqmdu: RTL and testbench
=========================

# seqmdu

Sequential multiply/divide unit for the EX stage, parametrised in operand width. It is the multi-cycle successor to the single-cycle ALU path: the ALU forwards `mulalu_func`/`mulalu_sign` and operands here, and this block computes MULT/MULTU/DIV/DIVU iteratively, one bit per cycle. While it runs, the pipeline is stalled through `busy`. Results go to the HI/LO register write port on `done`. A `cancel` input aborts an operation on exception or flush.

## Interface
- `WIDTH`, 32: operand width; the product is 2*WIDTH bits.
- `CNT_W`, $clog2(WIDTH)+1: iteration counter width.

- `clk` in 1: single clock; all state changes on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: request. Accepted only in IDLE or DONE, and only when `func` is `FUNC_MUL` or `FUNC_DIV`.
- `func` in `W_FUNC`: `FUNC_MUL` or `FUNC_DIV`. Any other value makes `start` a no-op.
- `sign` in 1: 1 = signed (MULT/DIV), 0 = unsigned.
- `source_a` in WIDTH: multiplicand or dividend. Latched on accept.
- `source_b` in WIDTH: multiplier or divisor. Latched on accept.
- `cancel` in 1: abort the current operation.
- `busy` out 1: high in PREP, CALC and FIX.
- `done` out 1: one-cycle pulse; `hi`/`lo` are valid in the same cycle.
- `hi` out WIDTH: product upper half, or remainder.
- `lo` out WIDTH: product lower half, or quotient.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE / DONE:
  - An accepted `start` latches `func`, `sign` and both operands, then moves to PREP.
  - With no accepted start, DONE returns to IDLE.
- PREP:
  - If `sign`=1, record the operand signs and replace each operand with its magnitude (two's-complement negate when the MSB is set).
  - Clear the accumulator and load the counter with WIDTH.
  - A divide with divisor 0 goes straight to FIX. Everything else goes to CALC.
- CALC, multiply: radix-2 shift-add into a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. The partial remainder is WIDTH+1 bits.
- CALC exit: the counter decrements each cycle; on reaching 0 the state moves to FIX.
- FIX, result write: registered `hi`/`lo` are written here and nowhere else, then the state moves to DONE.
- FIX, signed multiply: negate the 2*WIDTH product when the operand signs differ.
- FIX, signed divide:
  - Negate the quotient when the signs differ.
  - The remainder takes the sign of the dividend.
  - MIN / -1 gives quotient MIN, remainder 0, with no trap.
- FIX, divide by zero: `hi` = original `source_a`, `lo` = all ones, for both signed and unsigned.
- `cancel` in any non-IDLE state:
  - Next state is IDLE and no `done` is produced.
  - `hi`/`lo` keep their previous values, including when cancel arrives in FIX.
- `cancel` together with `start` in the same cycle: cancel wins and the start is dropped.
- Reset:
  - State IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0.
  - Counter and accumulators are cleared.
  - Reset applies in any state, including mid-CALC, with no residue.

## Timing
- `start` accepted in cycle 0:
  - PREP in cycle 1.
  - CALC in cycles 2 .. WIDTH+1.
  - FIX in cycle WIDTH+2.
  - `done` high in cycle WIDTH+3 (35 for WIDTH=32).
- Divide by zero: PREP in cycle 1, FIX in cycle 2, `done` in cycle 3.
- `busy` is high from cycle 1 through the FIX cycle inclusive. It is low in the `done` cycle.
- Back-to-back operation: a `start` in the `done` cycle is accepted, and `busy` rises the following cycle. The pipeline can issue the next op without a bubble.
- `start` while `busy` is ignored; the latched operands are unaffected.
- `hi`/`lo` are registered and held stable from `done` until the next FIX. They never change in CALC.

## Test plan
- Signed multiply, WIDTH=32, `sign`=1, `FUNC_MUL`, a=FFFFFFFD (-3), b=00000005:
  - `done` exactly 35 cycles after start.
  - `hi`=FFFFFFFF, `lo`=FFFFFFF1.
  - `busy` high for cycles 1–34.
- Unsigned multiply, `sign`=0, a=FFFFFFFF, b=FFFFFFFF:
  - `hi`=FFFFFFFE, `lo`=00000001.
  - A second start in the `done` cycle, signed 7*6, gives `hi`=0, `lo`=0000002A 35 cycles later.
- Divide sign rules:
  - Signed -7/2 gives `lo`=FFFFFFFD, `hi`=FFFFFFFF.
  - Signed 7/-2 gives `lo`=FFFFFFFD, `hi`=00000001.
  - Signed 80000000 / FFFFFFFF gives `lo`=80000000, `hi`=0.
- Divide by zero, unsigned 00000007 / 0:
  - `done` at cycle 3.
  - `hi`=00000007, `lo`=FFFFFFFF.
- Cancel mid-operation: `cancel` at cycle 10 of a multiply whose previous result was `hi`=1, `lo`=2.
  - IDLE at cycle 11, `busy`=0.
  - No `done` ever follows.
  - `hi`/`lo` stay 1/2.
  - Also repeat with `start`+`cancel` in the same cycle: the request is dropped.
- Reset and busy-start:
  - `rst_n`=0 at cycle 20 of a divide: the next cycle has all outputs 0 and IDLE, and a fresh start completes normally.
  - `start` with new operands while `busy`: ignored, and the result matches the original operands.

Source files
------------

// File: rtl/seqmdu.sv
// seqmdu - iterative multiply/divide unit for the EX stage.
//
// Computes MULT/MULTU (radix-2 shift-add, LSB first) and DIV/DIVU
// (restoring division, MSB first), one bit per clock. Operands are
// converted to magnitudes up front and the signs are applied in the
// final FIX cycle, so the iteration datapath is purely unsigned.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : synchronous active-low reset
//   start     : request, accepted in IDLE or DONE for FUNC_MUL/FUNC_DIV
//   func      : FUNC_MUL or FUNC_DIV; other codes make start a no-op
//   sign      : 1 = signed (MULT/DIV), 0 = unsigned
//   source_a  : multiplicand / dividend, latched on accept
//   source_b  : multiplier / divisor, latched on accept
//   cancel    : abort the operation; no done, hi/lo untouched
//   busy      : high in PREP, CALC and FIX (pipeline stall)
//   done      : one-cycle pulse, hi/lo valid in the same cycle
//   hi        : product upper half or remainder
//   lo        : product lower half or quotient
module seqmdu #(
    parameter int                 WIDTH    = 32,
    parameter int                 CNT_W    = $clog2(WIDTH) + 1,
    parameter int                 W_FUNC   = 2,
    parameter logic [W_FUNC-1:0]  FUNC_MUL = W_FUNC'(1),
    parameter logic [W_FUNC-1:0]  FUNC_DIV = W_FUNC'(2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W_FUNC-1:0] func,
    input  logic              sign,
    input  logic [WIDTH-1:0]  source_a,
    input  logic [WIDTH-1:0]  source_b,
    input  logic              cancel,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                accept_s;

    logic [W_FUNC-1:0]   func_r;
    logic                sign_r;
    logic [WIDTH-1:0]    a_r;        // multiplicand / dividend shift register
    logic [WIDTH-1:0]    b_r;        // multiplier shift register / divisor
    logic [WIDTH-1:0]    src_a_r;    // untouched dividend for divide-by-zero
    logic                sa_r;
    logic                sb_r;
    logic                dz_r;
    logic [2*WIDTH-1:0]  acc_r;      // product, or quotient in the low half
    logic [WIDTH-1:0]    rem_r;
    logic [CNT_W-1:0]    cnt_r;
    logic                busy_r;
    logic                done_r;
    logic [WIDTH-1:0]    hi_r;
    logic [WIDTH-1:0]    lo_r;

    logic                is_div_s;
    logic [WIDTH:0]      mul_sum_s;
    logic [WIDTH:0]      div_part_s;
    logic [WIDTH:0]      div_diff_s;
    logic                div_ge_s;
    logic [2*WIDTH-1:0]  prod_s;
    logic [WIDTH-1:0]    fix_hi_s;
    logic [WIDTH-1:0]    fix_lo_s;

    assign is_div_s = (func_r == FUNC_DIV);

    // Next-state decode; cancel overrides everything, including a same-cycle start.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (cancel) begin
                    state_s = ST_IDLE;
                end else if (start && ((func == FUNC_MUL) || (func == FUNC_DIV))) begin
                    accept_s = 1'b1;
                    state_s  = ST_PREP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PREP: begin
                if (cancel) begin
                    state_s = ST_IDLE;
                end else if (is_div_s && (b_r == {WIDTH{1'b0}})) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_CALC: begin
                if (cancel) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == CNT_W'(1)) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX: begin
                if (cancel) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // One iteration step for each operation.
    always_comb begin
        mul_sum_s  = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                     (b_r[0] ? {1'b0, a_r} : {(WIDTH+1){1'b0}});
        div_part_s = {rem_r, a_r[WIDTH-1]};
        div_diff_s = div_part_s - {1'b0, b_r};
        div_ge_s   = (div_part_s >= {1'b0, b_r});
    end

    // Sign fix-up and result selection written to hi/lo in FIX.
    always_comb begin
        prod_s   = (sa_r ^ sb_r) ? ({(2*WIDTH){1'b0}} - acc_r) : acc_r;
        fix_hi_s = {WIDTH{1'b0}};
        fix_lo_s = {WIDTH{1'b0}};
        if (dz_r) begin
            fix_hi_s = src_a_r;
            fix_lo_s = {WIDTH{1'b1}};
        end else if (!is_div_s) begin
            fix_hi_s = prod_s[2*WIDTH-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end else begin
            // MIN / -1 falls out naturally: negating MIN wraps back to MIN.
            fix_lo_s = (sa_r ^ sb_r) ? ({WIDTH{1'b0}} - acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            fix_hi_s = sa_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            func_r  <= {W_FUNC{1'b0}};
            sign_r  <= 1'b0;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
            src_a_r <= {WIDTH{1'b0}};
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            dz_r    <= 1'b0;
            acc_r   <= {(2*WIDTH){1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_PREP) || (state_s == ST_CALC) || (state_s == ST_FIX);
            done_r  <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (accept_s) begin
                        func_r  <= func;
                        sign_r  <= sign;
                        a_r     <= source_a;
                        b_r     <= source_b;
                        src_a_r <= source_a;
                    end
                end
                ST_PREP: begin
                    sa_r  <= sign_r & a_r[WIDTH-1];
                    sb_r  <= sign_r & b_r[WIDTH-1];
                    if (sign_r && a_r[WIDTH-1]) begin
                        a_r <= {WIDTH{1'b0}} - a_r;
                    end
                    if (sign_r && b_r[WIDTH-1]) begin
                        b_r <= {WIDTH{1'b0}} - b_r;
                    end
                    dz_r  <= is_div_s && (b_r == {WIDTH{1'b0}});
                    acc_r <= {(2*WIDTH){1'b0}};
                    rem_r <= {WIDTH{1'b0}};
                    cnt_r <= CNT_W'(WIDTH);
                end
                ST_CALC: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (!is_div_s) begin
                        // Add the multiplicand into the upper half, then shift the whole product right.
                        acc_r <= {mul_sum_s, acc_r[WIDTH-1:1]};
                        b_r   <= {1'b0, b_r[WIDTH-1:1]};
                    end else begin
                        a_r   <= {a_r[WIDTH-2:0], 1'b0};
                        acc_r <= {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-2:0], div_ge_s};
                        rem_r <= div_ge_s ? div_diff_s[WIDTH-1:0] : div_part_s[WIDTH-1:0];
                    end
                end
                ST_FIX: begin
                    if (!cancel) begin
                        hi_r <= fix_hi_s;
                        lo_r <= fix_lo_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_seqmdu.sv
// Directed testbench for seqmdu (WIDTH = 32).
module tb_seqmdu;

    localparam int         W     = 32;
    localparam logic [1:0] F_MUL = 2'b01;
    localparam logic [1:0] F_DIV = 2'b10;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   func = 2'b00;
    logic         sign = 1'b0;
    logic [W-1:0] source_a = '0;
    logic [W-1:0] source_b = '0;
    logic         cancel = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    seqmdu #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .func     (func),
        .sign     (sign),
        .source_a (source_a),
        .source_b (source_b),
        .cancel   (cancel),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue an op in the current cycle (cycle 0) and return in its done cycle.
    // poke > 0 re-asserts start with unrelated operands in that cycle while busy.
    task automatic run_op(input logic [1:0] f, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int poke, output int dcyc,
                          output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                          output int busy_err);
        func = f; sign = s; source_a = a; source_b = b; start = 1'b1;
        dcyc = -1; busy_err = 0; rhi = '0; rlo = '0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            start = 1'b0;
            if (done) begin
                if (busy) busy_err++;
                dcyc = c; rhi = hi; rlo = lo;
                break;
            end else if (!busy) begin
                busy_err++;
            end
            if (poke > 0 && c == poke) begin
                start = 1'b1; func = F_MUL; sign = 1'b0;
                source_a = 32'h1234_5678; source_b = 32'h9ABC_DEF0;
            end
        end
        start = 1'b0;
    endtask

    int           d;
    int           be;
    int           seen;
    logic [W-1:0] h;
    logic [W-1:0] l;

    initial begin
        repeat (3) tick();
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hi", 64'(hi), 64'd0);
        check("reset_lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        tick();

        // -3 * 5 signed
        run_op(F_MUL, 1'b1, 32'hFFFF_FFFD, 32'h0000_0005, 0, d, h, l, be);
        check("smul_done_cycle", 64'(d), 64'd35);
        check("smul_hi", 64'(h), 64'hFFFF_FFFF);
        check("smul_lo", 64'(l), 64'hFFFF_FFF1);
        check("smul_busy", 64'(be), 64'd0);
        tick();
        check("done_pulse_len", 64'(done), 64'd0);
        check("hold_hi", 64'(hi), 64'hFFFF_FFFF);
        check("hold_lo", 64'(lo), 64'hFFFF_FFF1);

        // unsigned max*max, then signed 7*6 back to back
        run_op(F_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, d, h, l, be);
        check("umul_hi", 64'(h), 64'hFFFF_FFFE);
        check("umul_lo", 64'(l), 64'h0000_0001);
        run_op(F_MUL, 1'b1, 32'h0000_0007, 32'h0000_0006, 0, d, h, l, be);
        check("b2b_done_cycle", 64'(d), 64'd35);
        check("b2b_hi", 64'(h), 64'h0);
        check("b2b_lo", 64'(l), 64'h0000_002A);
        check("b2b_busy", 64'(be), 64'd0);

        // divide sign rules
        run_op(F_DIV, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 0, d, h, l, be);
        check("sdiv_m7_2_q", 64'(l), 64'hFFFF_FFFD);
        check("sdiv_m7_2_r", 64'(h), 64'hFFFF_FFFF);
        check("sdiv_m7_2_cyc", 64'(d), 64'd35);
        run_op(F_DIV, 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0, d, h, l, be);
        check("sdiv_7_m2_q", 64'(l), 64'hFFFF_FFFD);
        check("sdiv_7_m2_r", 64'(h), 64'h0000_0001);
        run_op(F_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, d, h, l, be);
        check("sdiv_min_m1_q", 64'(l), 64'h8000_0000);
        check("sdiv_min_m1_r", 64'(h), 64'h0);

        // divide by zero
        run_op(F_DIV, 1'b0, 32'h0000_0007, 32'h0, 0, d, h, l, be);
        check("udz_done_cycle", 64'(d), 64'd3);
        check("udz_hi", 64'(h), 64'h0000_0007);
        check("udz_lo", 64'(l), 64'hFFFF_FFFF);
        check("udz_busy", 64'(be), 64'd0);
        run_op(F_DIV, 1'b1, 32'hFFFF_FFFB, 32'h0, 0, d, h, l, be);
        check("sdz_hi", 64'(h), 64'hFFFF_FFFB);
        check("sdz_lo", 64'(l), 64'hFFFF_FFFF);

        // previous result hi=1, lo=2, then cancel a multiply at cycle 10
        run_op(F_MUL, 1'b0, 32'h8000_0001, 32'h0000_0002, 0, d, h, l, be);
        check("pre_cancel_hi", 64'(h), 64'h1);
        check("pre_cancel_lo", 64'(l), 64'h2);
        tick();
        func = F_MUL; sign = 1'b0; source_a = 32'd3; source_b = 32'd5; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            start = 1'b0;
        end
        check("cancel_busy_before", 64'(busy), 64'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel_busy_after", 64'(busy), 64'd0);
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (done || busy) seen++;
        end
        check("cancel_no_done", 64'(seen), 64'd0);
        check("cancel_hi", 64'(hi), 64'h1);
        check("cancel_lo", 64'(lo), 64'h2);

        // start and cancel together: request dropped
        func = F_MUL; sign = 1'b0; source_a = 32'd3; source_b = 32'd5;
        start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (done || busy) seen++;
        end
        check("startcancel_dropped", 64'(seen), 64'd0);
        check("startcancel_hi", 64'(hi), 64'h1);
        check("startcancel_lo", 64'(lo), 64'h2);

        // reset at cycle 20 of a divide
        func = F_DIV; sign = 1'b0; source_a = 32'd100; source_b = 32'd7; start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            start = 1'b0;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_hi", 64'(hi), 64'h0);
        check("midrst_lo", 64'(lo), 64'h0);
        run_op(F_DIV, 1'b0, 32'd100, 32'd7, 0, d, h, l, be);
        check("postrst_cycle", 64'(d), 64'd35);
        check("postrst_q", 64'(l), 64'h0000_000E);
        check("postrst_r", 64'(h), 64'h0000_0002);

        // start with new operands while busy is ignored: -100 / 7 signed
        run_op(F_DIV, 1'b1, 32'hFFFF_FF9C, 32'd7, 5, d, h, l, be);
        check("busystart_cycle", 64'(d), 64'd35);
        check("busystart_q", 64'(l), 64'hFFFF_FFF2);
        check("busystart_r", 64'(h), 64'hFFFF_FFFE);
        check("busystart_busy", 64'(be), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
